// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for a switch/button-driven N-bit ALU: loads A, B and the opcode on
// successive presses, then captures the ALU result. Optional button filter: ALU_SEQ_DEBOUNCE_EN.
module alu_operand_sequencer #(
  parameter int N         = 4,
  parameter int OPW       = 3,
  parameter int DB_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   sw_data,
  input  logic [OPW-1:0] sw_op,
  input  logic           btn_load,
  input  logic [N-1:0]   alu_y,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  output logic [N-1:0]   result,
  output logic           result_valid,
  output logic [2:0]     state
);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  logic           sync1_r;
  logic           sync2_r;
  logic           sync3_r;
  logic           press_r;
  logic           level_s;
  logic [2:0]     state_r;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [OPW-1:0] op_r;
  logic [N-1:0]   res_r;
  logic           valid_r;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int             CW      = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic [CW-1:0] db_cnt_r;
  logic          filt_r;

  // Filtered level follows sync2 only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r <= '0;
      filt_r   <= 1'b0;
    end else if (sync2_r != filt_r) begin
      if (db_cnt_r == DB_LAST) begin
        filt_r   <= sync2_r;
        db_cnt_r <= '0;
      end else begin
        db_cnt_r <= db_cnt_r + CNT_ONE;
      end
    end else begin
      db_cnt_r <= '0;
    end
  end

  assign level_s = filt_r;
`else
  assign level_s = sync2_r;
`endif

  // Button synchronizer and registered rising-edge detect (one press per push).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      press_r <= 1'b0;
    end else begin
      sync1_r <= btn_load;
      sync2_r <= sync1_r;
      sync3_r <= level_s;
      press_r <= level_s & ~sync3_r;
    end
  end

  // Load sequence FSM; operand registers only change on the press that selects them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_A;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      res_r   <= '0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_A: begin
          if (press_r) begin
            a_r     <= sw_data;
            valid_r <= 1'b0;
            state_r <= S_B;
          end
        end
        S_B: begin
          if (press_r) begin
            b_r     <= sw_data;
            state_r <= S_OP;
          end
        end
        S_OP: begin
          if (press_r) begin
            op_r    <= sw_op;
            state_r <= S_EXEC;
          end
        end
        // ALU inputs have been stable for a full cycle; presses here are dropped.
        S_EXEC: begin
          res_r   <= alu_y;
          valid_r <= 1'b1;
          state_r <= S_SHOW;
        end
        S_SHOW: begin
          if (press_r) begin
            state_r <= S_A;
          end
        end
        default: begin
          state_r <= S_A;
        end
      endcase
    end
  end

  assign alu_a        = a_r;
  assign alu_b        = b_r;
  assign alu_op       = op_r;
  assign result       = res_r;
  assign result_valid = valid_r;
  assign state        = state_r;

endmodule
